// File: rtl/systolic_stream_bridge.sv
// systolic_stream_bridge
//   Byte-stream front end for a 4x4 8-bit systolic array. Operand bytes
//   (A then B, row-major, [0][0] first) are collected from a valid/ready
//   stream and presented in parallel with a one-cycle start pulse. The
//   bridge then waits for the array's result pulse and returns the
//   captured 4x4 result as a row-major valid/ready byte stream.
//
// Ports
//   i_clk, i_arst          clock, asynchronous active-high reset
//   i_inData/i_inValid     operand byte stream in
//   o_inReady              operand byte can be accepted (LOAD only)
//   o_a, o_b               operand matrices to the array, [row][col]
//   o_validInput           one-cycle start pulse to the array
//   i_c, i_validResult     result matrix and its valid pulse from the array
//   o_outData/o_outValid   result byte stream out
//   i_outReady             sink accepts a result byte
//   o_busy                 high in every state except LOAD
//   o_error                sticky timeout flag, cleared only by reset
module systolic_stream_bridge #(
   parameter int TIMEOUT_CYCLES = 31
) (
   input  logic                 i_clk,
   input  logic                 i_arst,
   input  logic [7:0]           i_inData,
   input  logic                 i_inValid,
   output logic                 o_inReady,
   output logic [3:0][3:0][7:0] o_a,
   output logic [3:0][3:0][7:0] o_b,
   output logic                 o_validInput,
   input  logic [3:0][3:0][7:0] i_c,
   input  logic                 i_validResult,
   output logic [7:0]           o_outData,
   output logic                 o_outValid,
   input  logic                 i_outReady,
   output logic                 o_busy,
   output logic                 o_error
);
   localparam logic [1:0] S_LOAD   = 2'd0;
   localparam logic [1:0] S_START  = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_UNLOAD = 2'd3;

   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES);

   logic [1:0]           state_q, state_d;
   logic [4:0]           k_q, k_d;
   logic [3:0]           j_q, j_d;
   logic [TW-1:0]        tmo_q, tmo_d;
   logic [3:0][3:0][7:0] a_q, a_d;
   logic [3:0][3:0][7:0] b_q, b_d;
   logic [3:0][3:0][7:0] res_q, res_d;
   logic                 error_q, error_d;
   logic                 in_fire, out_fire;

   assign o_inReady    = (state_q == S_LOAD);
   assign o_validInput = (state_q == S_START);
   assign o_outValid   = (state_q == S_UNLOAD);
   assign o_busy       = (state_q != S_LOAD);
   assign o_error      = error_q;
   assign o_a          = a_q;
   assign o_b          = b_q;
   // Selected straight from the held result, so it cannot move while
   // the sink stalls.
   assign o_outData    = res_q[j_q[3:2]][j_q[1:0]];

   assign in_fire  = i_inValid && o_inReady;
   assign out_fire = o_outValid && i_outReady;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      j_d     = j_q;
      tmo_d   = tmo_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      error_d = error_q;
      unique case (state_q)
         S_LOAD: begin
            if (in_fire) begin
               // k[4] selects B; k[3:2] is the row, k[1:0] the column.
               if (!k_q[4]) a_d[k_q[3:2]][k_q[1:0]] = i_inData;
               else         b_d[k_q[3:2]][k_q[1:0]] = i_inData;
               k_d = k_q + 5'd1;   // wraps to 0 after the 32nd byte
               if (k_q == 5'd31) state_d = S_START;
            end
         end
         S_START: begin
            tmo_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A result on the last allowed cycle still wins over the abort.
            if (i_validResult) begin
               res_d   = i_c;
               j_d     = 4'd0;
               state_d = S_UNLOAD;
            end else if (tmo_q == TMO_LAST) begin
               error_d = 1'b1;
               state_d = S_LOAD;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_UNLOAD: begin
            if (out_fire) begin
               j_d = j_q + 4'd1;
               if (j_q == 4'd15) state_d = S_LOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state_q <= S_LOAD;
         k_q     <= '0;
         j_q     <= '0;
         tmo_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         j_q     <= j_d;
         tmo_q   <= tmo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         error_q <= error_d;
      end
   end
endmodule

// File: tb/tb_systolic_stream_bridge.sv
// Bench for systolic_stream_bridge: a table of whole transactions (operands,
// array result, stimulus knobs) is replayed through one sequencing task that
// checks every observable step. Inputs change and outputs are sampled on the
// falling edge; the DUT has no combinational input-to-output paths.
module tb_systolic_stream_bridge;
   localparam int TMO = 31;

   typedef struct {
      logic [127:0] a;        // byte k at bits [k*8 +: 8], row-major
      logic [127:0] b;
      logic [127:0] c;        // result the modelled array returns
      bit           gaps;     // idle cycle before every operand byte
      int           spur_k;   // operand index carrying a stray result pulse
      int           bp_j;     // output index where the sink stalls
      int           bp_len;
      bit           respond;  // 0: array never answers
      int           rst_j;    // output index where reset hits
   } txn_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [7:0]           in_data = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [3:0][3:0][7:0] a_out, b_out;
   logic                 valid_input;
   logic [3:0][3:0][7:0] c_in = '0;
   logic                 vres = 1'b0;
   logic [7:0]           out_data;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic                 busy, error;

   int total = 0;
   int bad   = 0;
   int starts = 0;
   int nout   = 0;

   systolic_stream_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(clk), .i_arst(rst),
      .i_inData(in_data), .i_inValid(in_valid), .o_inReady(in_ready),
      .o_a(a_out), .o_b(b_out), .o_validInput(valid_input),
      .i_c(c_in), .i_validResult(vres),
      .o_outData(out_data), .o_outValid(out_valid), .i_outReady(out_ready),
      .o_busy(busy), .o_error(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (valid_input) starts <= starts + 1;
      if (out_valid && out_ready) nout <= nout + 1;
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic txn_t mk(input logic [127:0] a, b, c, input bit gaps,
                               input int spur_k, bp_j, bp_len, input bit respond,
                               input int rst_j);
      txn_t t;
      t.a = a; t.b = b; t.c = c; t.gaps = gaps; t.spur_k = spur_k;
      t.bp_j = bp_j; t.bp_len = bp_len; t.respond = respond; t.rst_j = rst_j;
      return t;
   endfunction

   task automatic run_txn(input txn_t t);
      int s0, n0;
      logic [255:0] ops;
      ops = {t.b, t.a};
      s0 = starts;
      n0 = nout;
      // operand load
      for (int i = 0; i < 32; i++) begin
         if (t.gaps) begin
            in_valid = 1'b0;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = ops[i*8 +: 8];
         vres     = (i == t.spur_k);
         c_in     = ~t.c;
         if (i == t.spur_k || i == t.spur_k + 1) begin
            chk("spur_in_ready", in_ready, 1);
            chk("spur_busy", busy, 0);
         end
         if (i == 31) chk("no_early_start", valid_input, 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      vres     = 1'b0;
      chk("start_pulse", valid_input, 1);
      chk("o_a", a_out, t.a);
      chk("o_b", b_out, t.b);
      if (!t.respond) begin
         repeat (TMO + 1) @(negedge clk);
         chk("tmo_last_wait_ready", in_ready, 0);
         chk("tmo_error_pre", error, 0);
         @(negedge clk);
         chk("tmo_error", error, 1);
         chk("tmo_in_ready", in_ready, 1);
         chk("tmo_busy", busy, 0);
         chk("tmo_starts", starts - s0, 1);
         chk("tmo_no_output", nout - n0, 0);
         return;
      end
      repeat (10) @(negedge clk);
      chk("wait_busy", busy, 1);
      chk("wait_single_pulse", valid_input, 0);
      vres = 1'b1;
      c_in = t.c;
      @(negedge clk);
      vres = 1'b0;
      c_in = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
      // result unload
      for (int j = 0; j < 16; j++) begin
         if (j == t.rst_j) begin
            rst = 1'b1;
            #1;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_valid_input", valid_input, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_error", error, 0);
            chk("rst_o_a", a_out, 0);
            chk("rst_o_b", b_out, 0);
            chk("rst_out_data", out_data, 0);
            @(negedge clk);
            rst = 1'b0;
            chk("rst_partial_count", nout - n0, t.rst_j);
            return;
         end
         chk("out_valid", out_valid, 1);
         chk("out_data", out_data, t.c[j*8 +: 8]);
         if (j == t.bp_j) begin
            out_ready = 1'b0;
            repeat (t.bp_len) begin
               @(negedge clk);
               chk("bp_valid_hold", out_valid, 1);
               chk("bp_data_hold", out_data, t.c[j*8 +: 8]);
            end
            out_ready = 1'b1;
         end
         @(negedge clk);
      end
      chk("done_in_ready", in_ready, 1);
      chk("done_busy", busy, 0);
      chk("done_out_valid", out_valid, 0);
      chk("done_error", error, 0);
      chk("done_starts", starts - s0, 1);
      chk("done_bytes", nout - n0, 16);
   endtask

   localparam logic [127:0] ID  = 128'h01000000_00010000_00000100_00000001;
   localparam logic [127:0] B16 = 128'h100F0E0D_0C0B0A09_08070605_04030201;
   localparam logic [127:0] R1  = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
   localparam logic [127:0] R2  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] R3  = 128'h80FF7F00_55AA33CC_11EE22DD_0FF0A5C3;

   txn_t tbl[7];

   initial begin
      //            a    b    c    gaps spur bp_j bp_len resp rst_j
      tbl[0] = mk(ID,  B16, B16, 0,   -1,  -1,  0,     1,   -1);
      tbl[1] = mk(ID,  B16, R1,  1,   -1,  -1,  0,     1,   -1);
      tbl[2] = mk(R2,  R3,  R1,  0,   -1,   5,  3,     1,   -1);
      tbl[3] = mk(R3,  R1,  R2,  0,    7,  -1,  0,     1,   -1);
      tbl[4] = mk(R1,  R2,  R3,  0,   -1,  -1,  0,     0,   -1);
      tbl[5] = mk(R2,  B16, R3,  0,   -1,  -1,  0,     1,    9);
      tbl[6] = mk(B16, ID,  R2,  1,   -1,  15,  2,     1,   -1);

      repeat (2) @(negedge clk);
      chk("reset_in_ready", in_ready, 1);
      chk("reset_valid_input", valid_input, 0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_error", error, 0);
      chk("reset_o_a", a_out, 0);
      chk("reset_o_b", b_out, 0);
      chk("reset_out_data", out_data, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int n = 0; n < 7; n++) begin
         run_txn(tbl[n]);
         repeat (2) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/systolic_stream_bridge.md
# systolic_stream_bridge

Byte-stream front end for the 4x4 8-bit systolic array top level. Accepts A and B operand matrices as a serial valid/ready byte stream, presents them in parallel with a one-cycle start pulse, and waits for the array's result-valid pulse. It then captures the 4x4 result and returns it as a serial valid/ready byte stream. It sits between a host-side streaming interface and the array's parallel ports.

## Interface
- TIMEOUT_CYCLES, 31: maximum cycles in WAIT before the error abort; minimum 11.
- i_clk  input  1  clock; all logic on rising edge.
- i_arst  input  1  asynchronous reset, active-high.
- i_inData  input  8  operand byte.
- i_inValid  input  1  operand byte valid.
- o_inReady  output  1  bridge can accept an operand byte.
- o_a  output  [3:0][3:0][7:0]  matrix A to the array, indexed [row][col].
- o_b  output  [3:0][3:0][7:0]  matrix B to the array, indexed [row][col].
- o_validInput  output  1  one-cycle start pulse to the array.
- i_c  input  [3:0][3:0][7:0]  result matrix from the array.
- i_validResult  input  1  result-valid pulse from the array.
- o_outData  output  8  result byte.
- o_outValid  output  1  result byte valid.
- i_outReady  input  1  sink accepts a result byte.
- o_busy  output  1  high in every state except LOAD.
- o_error  output  1  sticky timeout flag; cleared only by reset.

## Operation
- **FSM states:** LOAD, START, WAIT, UNLOAD. Reset state is LOAD.
- **LOAD:**
  - o_inReady=1. A byte is accepted when i_inValid && o_inReady.
  - 5-bit index k counts 0..31.
  - For k<16: o_a[k/4][k%4] <= byte. For k>=16: o_b[(k-16)/4][(k-16)%4] <= byte.
  - Accepting the byte at k=31 moves to START and clears k.
- **START:** o_validInput=1 for exactly one cycle, then WAIT. o_a/o_b are registered and hold their values until overwritten in the next LOAD.
- **WAIT:**
  - Timeout counter increments each cycle.
  - i_validResult=1 captures i_c into an internal result register and moves to UNLOAD.
  - If the counter reaches TIMEOUT_CYCLES first: set o_error and return to LOAD. No output is produced.
- **UNLOAD:**
  - o_outValid=1. o_outData = result[j/4][j%4], with 4-bit index j.
  - j advances on o_outValid && i_outReady.
  - The transfer at j=15 returns to LOAD.
- **i_validResult outside WAIT is ignored.** The array's free-running counter pulses it periodically when idle.
- **Data:** no arithmetic on data. Bytes pass through unmodified in row-major order, element [0][0] first.
- **Reset (any state):** returns to LOAD immediately. Partial loads and unsent results are discarded.

## Timing
- **Reset values:**
  - o_inReady=1.
  - o_validInput=0, o_outValid=0, o_busy=0, o_error=0.
  - o_a, o_b, o_outData all zero.
  - k, j and the timeout counter are 0.
- **Load rate:** o_inReady is combinational from state, so one byte can be accepted per cycle. Minimum load time is 32 cycles.
- **Start pulse:** o_validInput rises the cycle after the 32nd byte is accepted. o_a/o_b are final on that same cycle.
- **Capture:** i_c is sampled on the i_validResult cycle. o_outValid rises the next cycle, with o_outData=result[0][0].
- **Backpressure:**
  - o_outData is stable while o_outValid && !i_outReady.
  - o_outValid stays high across j without gaps while i_outReady=1, so 16 bytes take 16 cycles minimum.
- **Return to LOAD:** o_inReady rises the cycle after the last result transfer, or the cycle after timeout.
- **Timeout counter:** resets on WAIT entry. The abort fires on the cycle the counter equals TIMEOUT_CYCLES without i_validResult. If i_validResult arrives on that same cycle, the capture wins.
- **End-to-end latency with the array:** start pulse, then i_validResult 10 cycles later. First result byte is 12 cycles after the last operand byte is accepted.

## Test plan
- **Identity:** A = identity, B bytes 1..16 streamed with i_validResult modelled 10 cycles after o_validInput, i_c echoing B -> exactly one o_validInput pulse; o_outData sequence 1..16; o_busy low afterwards.
- **Input gaps:** i_inValid toggling every other cycle during load -> o_a/o_b identical to the gap-free case; o_validInput only after the 32nd accepted byte.
- **Output backpressure:** i_outReady low for 3 cycles at j=5 -> o_outData holds result[1][1] and o_outValid stays 1; all 16 bytes delivered once, in order.
- **Timeout:** i_validResult tied 0 -> o_error=1 at TIMEOUT_CYCLES cycles after WAIT entry; o_inReady=1 the next cycle; no o_outValid.
- **Spurious result pulse:** i_validResult pulsed during LOAD at k=7 -> no state change; k continues to 8.
- **Reset mid-operation:** i_arst asserted during UNLOAD at j=9 -> all outputs at reset values; the next full transaction completes correctly with o_error=0.
